// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of the bubbles inserted for load-use hazards.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_regwrite,
  input  logic             id_alusrc,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic [1:0]       id_aluop,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             ex_flush,
  input  logic             ex_hold,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_alusrc,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [1:0]       ex_aluop,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_count
);

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            alusrc;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            branch;
    logic            jump;
    logic [1:0]      aluop;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } ex_bundle_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_bundle_t      ex_q, ex_d, id_bundle;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            rs1_used, rs2_used, load_use;

  assign id_bundle = '{
    valid:    id_valid,
    regwrite: id_regwrite,
    alusrc:   id_alusrc,
    memread:  id_memread,
    memwrite: id_memwrite,
    memtoreg: id_memtoreg,
    branch:   id_branch,
    jump:     id_jump,
    aluop:    id_aluop,
    rs1:      id_rs1,
    rs2:      id_rs2,
    rd:       id_rd,
    pc:       id_pc,
    rs1_data: id_rs1_data,
    rs2_data: id_rs2_data,
    imm:      id_imm
  };

  // JAL carries garbage in its rs1 field; JALR (alusrc=1) genuinely reads rs1.
  assign rs1_used = (id_regwrite | id_memwrite | id_branch) & ~(id_jump & ~id_alusrc);
  assign rs2_used = id_memwrite | id_branch | (id_regwrite & ~id_alusrc & ~id_jump);

  assign load_use = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & id_valid &
                    ((rs1_used & (id_rs1 == ex_q.rd)) | (rs2_used & (id_rs2 == ex_q.rd)));

  assign stall = ex_hold | (load_use & ~ex_flush);

  // Hold beats flush: EX re-asserts the flush once it is able to advance.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (ex_hold) begin
      ex_d = ex_q;
    end else if (ex_flush) begin
      ex_d = '0;
    end else if (load_use) begin
      ex_d = '0;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else begin
      ex_d = id_bundle;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears the whole bundle, not just valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_memread   = ex_q.memread;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign ex_aluop     = ex_q.aluop;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign bubble_count = cnt_q;

endmodule
